// File: rtl/uart_pkg.sv
// Shared definitions for the Retro16 UART block: register map, STATUS/CTRL bit
// positions and the TX sequencer state encoding.
package uart_pkg;

  localparam logic [1:0] UART_DATA    = 2'd0;
  localparam logic [1:0] UART_STATUS  = 2'd1;
  localparam logic [1:0] UART_DIVISOR = 2'd2;
  localparam logic [1:0] UART_CTRL    = 2'd3;

  localparam int ST_RX_NONEMPTY   = 0;
  localparam int ST_RX_FULL       = 1;
  localparam int ST_OVERRUN       = 2;
  localparam int ST_TX_HOLD_EMPTY = 3;
  localparam int ST_TX_BUSY       = 4;

  localparam int CTRL_RX_IRQ_EN = 0;
  localparam int CTRL_TX_IRQ_EN = 1;
  localparam int CTRL_RX_EN     = 2;

  localparam logic [2:0] CTRL_RESET = 3'b100;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_WAIT = 1'b1
  } tx_state_e;

endpackage

// File: rtl/uart_bus_if.sv
// Retro16 peripheral bus as seen by one UART instance.
// Handshake: bus_rd / bus_wr are single-cycle strobes with no ready; a write is
// taken on the edge it is sampled, read data is valid from the following edge
// and holds until the next read. rd and wr together count as a write only.
interface uart_bus_if;
  logic [1:0]  bus_addr;
  logic        bus_rd;
  logic        bus_wr;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata;

  modport master (output bus_addr, bus_rd, bus_wr, bus_wdata, input bus_rdata);
  modport slave  (input bus_addr, bus_rd, bus_wr, bus_wdata, output bus_rdata);
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO for received data. A pop on empty is ignored and the
// head reads as zero; a push while full is taken only if a pop frees a slot.
module uart_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign dout      = empty ? 8'h00 : r_mem[r_rd_ptr];
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointers are AW bits wide, so they wrap at DEPTH (a power of two).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/uart_controller.sv
// Memory-mapped UART control block: baud oversample generator, RX capture FIFO,
// register file and the TX start sequencer with its one-byte holding register.
module uart_controller
  import uart_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd53
) (
  input  logic        clk,
  input  logic        reset_n,
  uart_bus_if.slave   bus,
  output logic        irq,
  output logic        baud_oversample_clk,
  input  logic        rx_byte_valid,
  input  logic [7:0]  rx_byte_data,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output tx_state_e   dbg_tx_state
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [15:0] r_divisor, r_div_cnt, r_rdata;
  logic [2:0]  r_ctrl;
  logic        r_overrun, r_rx_valid_q, r_hold_full, r_tx_start, r_irq;
  logic [7:0]  r_hold, r_tx_data;
  tx_state_e   r_state, w_state_nxt;

  logic          w_wr, w_rd, w_push, w_pop, w_start, w_hold_accept;
  logic          w_full, w_empty;
  logic [7:0]    w_fifo_dout;
  logic [CW-1:0] w_count;
  logic [15:0]   w_status, w_rd_mux;

  assign w_wr   = bus.bus_wr;
  assign w_rd   = bus.bus_rd & ~bus.bus_wr;
  assign w_push = rx_byte_valid & ~r_rx_valid_q & r_ctrl[CTRL_RX_EN];
  assign w_pop  = w_rd & (bus.bus_addr == UART_DATA);
  // The slot freed by a TX start this cycle is immediately reusable.
  assign w_hold_accept = w_wr & (bus.bus_addr == UART_DATA) & (~r_hold_full | w_start);

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .pop     (w_pop),
    .din     (rx_byte_data),
    .dout    (w_fifo_dout),
    .count   (w_count),
    .full    (w_full),
    .empty   (w_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      TX_IDLE: if (r_hold_full && !tx_busy) begin
        w_start     = 1'b1;
        w_state_nxt = TX_WAIT;
      end
      TX_WAIT: w_state_nxt = TX_IDLE;
      default: w_state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    w_status                   = '0;
    w_status[ST_RX_NONEMPTY]   = ~w_empty;
    w_status[ST_RX_FULL]       = w_full;
    w_status[ST_OVERRUN]       = r_overrun;
    w_status[ST_TX_HOLD_EMPTY] = ~r_hold_full;
    w_status[ST_TX_BUSY]       = tx_busy;
    w_status[11:8]             = 4'(w_count);
    case (bus.bus_addr)
      UART_DATA:    w_rd_mux = {8'h00, w_fifo_dout};
      UART_STATUS:  w_rd_mux = w_status;
      UART_DIVISOR: w_rd_mux = r_divisor;
      default:      w_rd_mux = {13'b0, r_ctrl};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= TX_IDLE;
      r_divisor    <= DEFAULT_DIV;
      r_div_cnt    <= '0;
      r_rdata      <= '0;
      r_ctrl       <= CTRL_RESET;
      r_overrun    <= 1'b0;
      r_rx_valid_q <= 1'b0;
      r_hold_full  <= 1'b0;
      r_hold       <= '0;
      r_tx_start   <= 1'b0;
      r_tx_data    <= '0;
      r_irq        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rx_valid_q <= rx_byte_valid;
      r_tx_start   <= w_start;
      if (w_start) r_tx_data <= r_hold;
      if (w_rd) r_rdata <= w_rd_mux;

      if (w_wr && bus.bus_addr == UART_DIVISOR) begin
        r_divisor <= bus.bus_wdata;
        r_div_cnt <= '0;
      end else if (r_div_cnt >= r_divisor) begin
        r_div_cnt <= '0;
      end else begin
        r_div_cnt <= r_div_cnt + 16'd1;
      end

      if (w_wr && bus.bus_addr == UART_CTRL) r_ctrl <= bus.bus_wdata[2:0];
      if (w_wr && bus.bus_addr == UART_STATUS && bus.bus_wdata[ST_OVERRUN]) r_overrun <= 1'b0;
      if (w_push && w_full && !w_pop) r_overrun <= 1'b1;

      if (w_hold_accept) begin
        r_hold_full <= 1'b1;
        r_hold      <= bus.bus_wdata[7:0];
      end else if (w_start) begin
        r_hold_full <= 1'b0;
      end

      r_irq <= (r_ctrl[CTRL_RX_IRQ_EN] & (~w_empty | r_overrun)) |
               (r_ctrl[CTRL_TX_IRQ_EN] & ~r_hold_full);
    end
  end

  assign bus.bus_rdata        = r_rdata;
  assign irq                  = r_irq;
  assign baud_oversample_clk  = (r_div_cnt == r_divisor);
  assign tx_start             = r_tx_start;
  assign tx_data              = r_tx_data;
  assign dbg_tx_state         = r_state;
endmodule
